asps_fee_meter: RTL
===================

Name: asps_fee_meter

Overview:
- Billing stage directly downstream of the parking controller in the Alamein Smart Parking System.
- Consumes the controller's one-cycle entry_detected/exit_detected pulses plus the 2-bit car id.
- Keeps a per-car entry timestamp, computes the parking fee on exit (elapsed time units × rate, with a minimum charge), and accumulates total revenue.
- Feeds the cost display and audit logic.

Parameters:
- TICK_DIV, 1: clock cycles per billing time unit (1 = one unit per clk).
- COST_RATE, 2: cost per time unit; also the minimum charge.
- TIME_W, 16: width of the time-unit counter and stored timestamps.
- COST_W, 8: width of the per-car cost output; saturating.
- REV_W, 16: width of the accumulated revenue; saturating.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- entry_detected  in  1  one-cycle pulse: car with id entered.
- exit_detected  in  1  one-cycle pulse: car with id exited.
- id  in  2  car id; 1..3 valid, 0 invalid.
- cost  out  COST_W  fee of the most recently billed car, held until the next bill.
- cost_valid  out  1  one-cycle pulse when cost updates.
- total_revenue  out  REV_W  sum of all billed costs.
- active_mask  out  3  bit k-1 set while car k is parked.
- busy  out  1  billing FSM not in IDLE.
- err_dup_entry  out  1  pulse: entry for an id already parked, or id=0.
- err_unknown_exit  out  1  pulse: exit for an id not parked, or id=0.
- err_overrun  out  1  pulse: exit arrived while busy; that exit is dropped.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, time counter 0, prescaler 0, all slots invalid, FSM=IDLE. Reset mid-bill abandons the bill with no cost_valid and no revenue update.
- Time base:
  - Prescaler counts 0..TICK_DIV-1.
  - time_now increments modulo 2^TIME_W on each prescaler wrap.
  - TICK_DIV=1 means time_now increments every clk.
- Entry (sampled on a clk edge with entry_detected=1):
  - id=0 or active_mask[id-1]=1 → err_dup_entry=1 next cycle; stored state unchanged.
  - Otherwise entry_time[id]=time_now and active_mask[id-1]=1.
  - Entry handling is independent of busy.
- Exit:
  - id=0 or slot inactive → err_unknown_exit; nothing else happens.
  - FSM != IDLE → err_overrun; slot is not cleared.
  - Otherwise, in IDLE: elapsed = (time_now − entry_time[id]) mod 2^TIME_W is latched, active_mask[id-1] is cleared, and the FSM goes to MULT.
- FSM:
  - IDLE → MULT on an accepted exit.
  - MULT: product = elapsed × COST_RATE, width TIME_W+8. If elapsed=0, charge = COST_RATE. Charge saturates to 2^COST_W−1. Then → REPORT.
  - REPORT: cost ← charge; cost_valid=1 for one cycle; total_revenue ← saturating add (clamps at 2^REV_W−1). Then → IDLE.
- Latency: for an exit sampled at edge N, cost and cost_valid update at edge N+2. busy is high for the two cycles after edge N. The next exit is accepted from edge N+3.
- Simultaneous entry and exit in the same cycle:
  - Exit is evaluated first against pre-edge state.
  - If both use the same id and the exit is accepted, the entry is also accepted: valid stays 1 and entry_time is set to time_now.
  - If the exit is rejected, the entry follows its own rules against pre-edge state.
- Error pulses are registered and last exactly one cycle.
- Stays ≥ 2^TIME_W units alias (documented limitation).

Optional Feature:
- Macro: ASPS_GRACE_PERIOD_EN.
- Defined: adds parameter GRACE_UNITS (default 3). Elapsed < GRACE_UNITS gives charge 0; cost_valid still pulses and revenue is unchanged. The minimum-charge rule applies only when elapsed ≥ GRACE_UNITS.
- Undefined: no grace period; elapsed=0 charges COST_RATE.

Decomposition:
- asps_pkg holds:
  - FSM state enum (IDLE, MULT, REPORT).
  - ID_W=2 and NUM_CARS=3.
  - Default COST_RATE, COST_W, TIME_W.
  - Saturating-add function.
- Sub-module asps_time_base: prescaler plus time_now counter, parameterised by TICK_DIV and TIME_W.

Test Plan:
- Reset: drive reset=0 with prior state → cost=0, total_revenue=0, active_mask=000, busy=0, all error flags 0.
- Basic bill: entry id1, exit id1 20 cycles later → cost=40 and cost_valid for 1 cycle at edge +2, total_revenue=40, active_mask=000.
- Errors: exit id2 unparked → err_unknown_exit pulse with no cost_valid; entry id1 twice then exit 5 cycles after the first entry → err_dup_entry once, cost=10.
- Saturation and minimum: id3 parked 200 cycles → cost=255; entry then exit after 0 elapsed units → cost=2 (with ASPS_GRACE_PERIOD_EN: 0, revenue unchanged).
- Overrun and concurrency: exit id1 then exit id2 one cycle later → err_overrun, id2 stays active. Same-cycle exit+entry on id2 → bill issued and id2 re-armed with the new timestamp.

Source files
------------

// File: rtl/asps_pkg.sv
// Shared types, sizes and helpers for the Alamein Smart Parking fee meter.
package asps_pkg;

   localparam int ID_W          = 2;
   localparam int NUM_CARS      = 3;
   localparam int DEF_COST_RATE = 2;
   localparam int DEF_COST_W    = 8;
   localparam int DEF_TIME_W    = 16;
   localparam int DEF_REV_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MULT   = 2'd1,
      REPORT = 2'd2
   } fee_state_e;

   // Clamps a + b at max_val; operands are zero-extended into 32 bits.
   function automatic logic [31:0] sat_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] max_val);
      logic [32:0] sum;
      logic [31:0] result;
      sum = {1'b0, a} + {1'b0, b};
      if (sum > {1'b0, max_val}) result = max_val;
      else                       result = sum[31:0];
      return result;
   endfunction

endpackage

// File: rtl/asps_time_base.sv
// Billing time base: a prescaler dividing clk by TICK_DIV drives a free-running
// time-unit counter that wraps modulo 2^TIME_W.
module asps_time_base #(
   parameter int TICK_DIV = 1,
   parameter int TIME_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   output logic [TIME_W-1:0] time_now
);

   localparam int            PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

   logic [PW-1:0]     pre_q, pre_d;
   logic [TIME_W-1:0] time_q, time_d;

   always_comb begin
      pre_d  = pre_q;
      time_d = time_q;
      if (pre_q == PRE_MAX) begin
         pre_d  = '0;
         time_d = time_q + TIME_W'(1);
      end else begin
         pre_d  = pre_q + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q  <= '0;
         time_q <= '0;
      end else begin
         pre_q  <= pre_d;
         time_q <= time_d;
      end
   end

   assign time_now = time_q;

endmodule

// File: rtl/asps_fee_meter.sv
// Parking fee meter: per-car entry timestamps, fee computation on exit and
// saturating revenue. Optional grace period via `define ASPS_GRACE_PERIOD_EN.
module asps_fee_meter
   import asps_pkg::*;
#(
   parameter int TICK_DIV  = 1,
   parameter int COST_RATE = DEF_COST_RATE,
   parameter int TIME_W    = DEF_TIME_W,
   parameter int COST_W    = DEF_COST_W,
   parameter int REV_W     = DEF_REV_W
`ifdef ASPS_GRACE_PERIOD_EN
   ,
   parameter int GRACE_UNITS = 3
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                entry_detected,
   input  logic                exit_detected,
   input  logic [ID_W-1:0]     id,
   output logic [COST_W-1:0]   cost,
   output logic                cost_valid,
   output logic [REV_W-1:0]    total_revenue,
   output logic [NUM_CARS-1:0] active_mask,
   output logic                busy,
   output logic                err_dup_entry,
   output logic                err_unknown_exit,
   output logic                err_overrun
);

   localparam int                PROD_W     = TIME_W + 8;
   localparam logic [PROD_W-1:0] COST_LIMIT = PROD_W'({COST_W{1'b1}});
   localparam logic [REV_W-1:0]  REV_MAX    = '1;

   logic [TIME_W-1:0] time_now;

   asps_time_base #(.TICK_DIV(TICK_DIV), .TIME_W(TIME_W)) u_time_base (
      .clk      (clk),
      .reset    (reset),
      .time_now (time_now)
   );

   fee_state_e          state_q, state_d;
   logic [TIME_W-1:0]   entry_time_q [1:NUM_CARS];
   logic [TIME_W-1:0]   entry_time_d [1:NUM_CARS];
   logic [NUM_CARS-1:0] active_q, active_d;
   logic [TIME_W-1:0]   elapsed_q, elapsed_d;
   logic [COST_W-1:0]   charge_q, charge_d;
   logic [COST_W-1:0]   cost_q, cost_d;
   logic                cost_valid_q, cost_valid_d;
   logic [REV_W-1:0]    revenue_q, revenue_d;
   logic                dup_q, dup_d, unk_q, unk_d, ovr_q, ovr_d;

   logic [NUM_CARS-1:0] slot_bit;
   logic                slot_active, exit_accept, grace_hit;
   logic [TIME_W-1:0]   mult_in;
   logic [PROD_W-1:0]   product;
   logic [COST_W-1:0]   charge_calc;

   always_comb begin
      for (int k = 1; k <= NUM_CARS; k++) slot_bit[k-1] = (id == ID_W'(k));
   end

   assign slot_active = |(slot_bit & active_q);
   assign exit_accept = exit_detected && slot_active && (state_q == IDLE);

`ifdef ASPS_GRACE_PERIOD_EN
   assign grace_hit = (elapsed_q < TIME_W'(GRACE_UNITS));
`else
   assign grace_hit = 1'b0;
`endif

   // Zero elapsed is billed as one unit, which yields the minimum charge.
   assign mult_in     = (elapsed_q == '0) ? TIME_W'(1) : elapsed_q;
   assign product     = PROD_W'(mult_in) * PROD_W'(COST_RATE);
   assign charge_calc = grace_hit ? '0 :
                        (product > COST_LIMIT) ? COST_W'(COST_LIMIT) : COST_W'(product);

   always_comb begin
      state_d      = state_q;
      entry_time_d = entry_time_q;
      active_d     = active_q;
      elapsed_d    = elapsed_q;
      charge_d     = charge_q;
      cost_d       = cost_q;
      cost_valid_d = 1'b0;
      revenue_d    = revenue_q;
      dup_d        = 1'b0;
      unk_d        = 1'b0;
      ovr_d        = 1'b0;

      if (exit_detected) begin
         if (!slot_active) begin
            unk_d = 1'b1;
         end else if (state_q != IDLE) begin
            ovr_d = 1'b1;
         end else begin
            elapsed_d = time_now - entry_time_q[id];
            active_d  = active_q & ~slot_bit;
            state_d   = MULT;
         end
      end

      // An accepted exit frees the slot first, so a same-cycle entry re-arms it.
      if (entry_detected) begin
         if ((id == '0) || (slot_active && !exit_accept)) begin
            dup_d = 1'b1;
         end else begin
            entry_time_d[id] = time_now;
            active_d         = active_d | slot_bit;
         end
      end

      case (state_q)
         MULT: begin
            charge_d = charge_calc;
            state_d  = REPORT;
         end
         REPORT: begin
            cost_d       = charge_q;
            cost_valid_d = 1'b1;
            revenue_d    = REV_W'(sat_add(32'(revenue_q), 32'(charge_q), 32'(REV_MAX)));
            state_d      = IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         for (int i = 1; i <= NUM_CARS; i++) entry_time_q[i] <= '0;
         active_q     <= '0;
         elapsed_q    <= '0;
         charge_q     <= '0;
         cost_q       <= '0;
         cost_valid_q <= 1'b0;
         revenue_q    <= '0;
         dup_q        <= 1'b0;
         unk_q        <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         entry_time_q <= entry_time_d;
         active_q     <= active_d;
         elapsed_q    <= elapsed_d;
         charge_q     <= charge_d;
         cost_q       <= cost_d;
         cost_valid_q <= cost_valid_d;
         revenue_q    <= revenue_d;
         dup_q        <= dup_d;
         unk_q        <= unk_d;
         ovr_q        <= ovr_d;
      end
   end

   assign cost             = cost_q;
   assign cost_valid       = cost_valid_q;
   assign total_revenue    = revenue_q;
   assign active_mask      = active_q;
   assign busy             = (state_q != IDLE);
   assign err_dup_entry    = dup_q;
   assign err_unknown_exit = unk_q;
   assign err_overrun      = ovr_q;

endmodule
